// File: rtl/reverse_bits_rx.sv
// Serial bit reverser on a valid/ready word stream: one word in, DATA_WIDTH shift
// cycles, result held until accepted. Also counts delivered words.
//
// state | meaning
// IDLE  | ready for a word; in_ready high
// SHIFT | moving src LSB-first into dst, one bit per cycle
// HOLD  | dout valid; waiting for out_ready
module reverse_bits_rx #(
    parameter int  DATA_WIDTH  = 32,
    parameter int  COUNT_WIDTH = 8,
    localparam int BIT_CNT_W   = $clog2(DATA_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  din,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  dout,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] word_count
);
    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

    state_t                 state;
    logic [DATA_WIDTH-1:0]  src;
    logic [DATA_WIDTH-1:0]  dst;
    logic [BIT_CNT_W-1:0]   bit_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            src        <= '0;
            dst        <= '0;
            bit_cnt    <= '0;
            word_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        src     <= din;
                        dst     <= '0;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // LSB of src lands in the LSB of dst; after DATA_WIDTH shifts it is the MSB.
                    dst     <= {dst[DATA_WIDTH-2:0], src[0]};
                    src     <= src >> 1;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        word_count <= word_count + 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == HOLD);
    assign busy      = (state == SHIFT) || (state == HOLD);
    assign dout      = dst;

endmodule

// File: tb/tb_reverse_bits_rx.sv
// Directed bench for reverse_bits_rx: a 32-bit instance checked through a scoreboard
// queue, plus an 8-bit instance with a 2-bit counter for the wrap case.
module tb_reverse_bits_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [31:0] din, dout;
    logic [7:0]  word_count;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
    logic [7:0]  din8, dout8;
    logic [1:0]  wc8;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [31:0] exp_q[$];

    reverse_bits_rx #(.DATA_WIDTH(32), .COUNT_WIDTH(8)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .din(din),
        .out_valid(out_valid), .out_ready(out_ready), .dout(dout),
        .busy(busy), .word_count(word_count)
    );

    reverse_bits_rx #(.DATA_WIDTH(8), .COUNT_WIDTH(2)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8), .din(din8),
        .out_valid(out_valid8), .out_ready(out_ready8), .dout(dout8),
        .busy(busy8), .word_count(wc8)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every delivery on the 32-bit instance must match the oldest pushed word.
    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_unexpected observed %0h expected no delivery", dout);
            end else begin
                chk("sb_dout", dout, exp_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed running expected finished");
        $fatal(1, "timeout");
    end

    // Waits for in_ready, accepts w, returns accept cycle and accept-to-out_valid latency.
    task automatic send(input logic [31:0] w, input logic [31:0] exp, input bit keep_valid,
                        output int acc_cyc, output int lat);
        int t = 0;
        in_valid = 1'b1;
        din      = w;
        while (in_ready !== 1'b1 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        @(posedge clk);
        acc_cyc = cyc;
        exp_q.push_back(exp);
        #1;
        if (!keep_valid) in_valid = 1'b0;
        lat = 0;
        @(negedge clk);
        while (out_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic send8(input logic [7:0] w, input logic [7:0] exp, input logic [1:0] exp_wc);
        int lat = 0;
        in_valid8 = 1'b1;
        din8      = w;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        @(negedge clk);
        while (out_valid8 !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("w8_latency", 32'(lat), 32'd8);
        chk("w8_dout", 32'(dout8), 32'(exp));
        @(posedge clk); #1;
        @(negedge clk);
        chk("w8_count", 32'(wc8), 32'(exp_wc));
        chk("w8_in_ready", 32'(in_ready8), 32'd1);
    endtask

    logic [31:0] words [4] = '{32'h1234_5678, 32'hFFFF_0000, 32'hA5A5_A5A5, 32'h0000_0000};
    logic [31:0] revs  [4] = '{32'h1E6A_2C48, 32'h0000_FFFF, 32'hA5A5_A5A5, 32'h0000_0000};
    logic [7:0]  w8    [5] = '{8'h01, 8'h02, 8'h0F, 8'h3C, 8'hA0};
    logic [7:0]  r8    [5] = '{8'h80, 8'h40, 8'hF0, 8'h3C, 8'h05};
    logic [1:0]  c8    [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    initial begin
        int lat, acc, prev_acc;

        // Reset with garbage on the inputs.
        rst        = 1'b1;
        out_ready  = 1'b1;
        in_valid8  = 1'b0;
        din8       = '0;
        out_ready8 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'($urandom);
            din      = $urandom;
            @(posedge clk); #1;
            @(negedge clk);
            chk("rst_in_ready", 32'(in_ready), 32'd1);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_dout", dout, 32'd0);
            chk("rst_count", 32'(word_count), 32'd0);
        end
        @(posedge clk); #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);

        // Single word.
        send(32'h0000_0001, 32'h8000_0000, 1'b0, acc, lat);
        chk("single_latency", 32'(lat), 32'd32);
        chk("single_dout", dout, 32'h8000_0000);
        chk("single_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("single_out_valid_drop", 32'(out_valid), 32'd0);
        chk("single_in_ready", 32'(in_ready), 32'd1);
        chk("single_count", 32'(word_count), 32'd1);

        // Back-to-back pattern stream with in_valid held high.
        prev_acc = 0;
        for (int i = 0; i < 4; i++) begin
            send(words[i], revs[i], (i < 3), acc, lat);
            chk("stream_latency", 32'(lat), 32'd32);
            if (i > 0) chk("stream_spacing", 32'(acc - prev_acc), 32'd34);
            prev_acc = acc;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("stream_count", 32'(word_count), 32'd5);

        // Backpressure: out_ready low for 10 cycles while a new word is offered.
        out_ready = 1'b0;
        send(32'h0000_00F0, 32'h0F00_0000, 1'b0, acc, lat);
        chk("bp_latency", 32'(lat), 32'd32);
        in_valid = 1'b1;
        din      = 32'hFFFF_FFFF;
        for (int i = 0; i < 10; i++) begin
            chk("bp_dout", dout, 32'h0F00_0000);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            if (i == 9) begin
                out_ready = 1'b1;
                in_valid  = 1'b0;
            end
            @(negedge clk);
        end
        chk("bp_count_held", 32'(word_count), 32'd5);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_delivered", 32'(out_valid), 32'd0);
        chk("bp_count", 32'(word_count), 32'd6);
        chk("bp_not_captured", 32'(busy), 32'd0);

        // Reset 15 cycles after accepting a word.
        in_valid = 1'b1;
        din      = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (14) begin
            @(posedge clk); #1;
        end
        chk("mid_busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_in_ready", 32'(in_ready), 32'd1);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_dout", dout, 32'd0);
        chk("mid_count", 32'(word_count), 32'd0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("mid_no_out_valid", 32'(out_valid), 32'd0);
        end
        send(32'h0000_0003, 32'hC000_0000, 1'b0, acc, lat);
        chk("mid_next_latency", 32'(lat), 32'd32);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_next_count", 32'(word_count), 32'd1);

        // 8-bit instance, 2-bit counter wraps.
        for (int i = 0; i < 5; i++) send8(w8[i], r8[i], c8[i]);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
